hdmi_rd_sched: RTL and testbench
================================

# hdmi_rd_sched

Frame-read scheduler for the HDMI output path. It issues fixed-length 256-bit read bursts to the DDR read-command port so the display-side line buffer stays above its refill threshold. It walks a frame from a selectable base address, restarts on every vsync rising edge, and reports frame completion and frame-sync errors. It sits between the DDR controller read port and the HDMI 256-to-16 line buffer, whose fill level it monitors.

## Interface
- BURST_LEN, 240: 256-bit words per burst (≥2).
- BURSTS_PER_FRAME, 540: bursts per frame (1920×1080×16 bit / 256 / 240).
- FILL_THRESH, 1920: request a burst only when buf_level ≤ this.
- FRAME_BASE0, 32'h0000_0000: byte base of frame buffer 0.
- FRAME_BASE1, 32'h0080_0000: byte base of frame buffer 1.
- hdmi_clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = schedule frames.
- hdmi_vsync  in  1  raw vsync, synchronous to hdmi_clk; frame starts on its rising edge.
- frame_sel  in  1  buffer the writer last completed; sampled at frame start.
- buf_level  in  16  downstream buffer fill count.
- rd_cmd_valid  out  1  burst command valid.
- rd_cmd_ready  in  1  DDR controller accepts the command.
- rd_cmd_addr  out  32  burst byte address.
- rd_cmd_len  out  16  constant BURST_LEN.
- rd_beat  in  1  one 256-bit data word returned this cycle.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse when the last beat of a frame is received.
- frame_err  out  1  one-cycle pulse when vsync cut a frame short.

## Operation
- States: IDLE, WAIT_VS, CHECK, CMD, DATA, FRAME_END.
- IDLE → WAIT_VS when enable = 1.
- WAIT_VS: on a vsync rising edge (vsync & ~vsync_d), latch base = frame_sel ? FRAME_BASE1 : FRAME_BASE0. Set addr = base, burst_idx = 0, then go to CHECK.
- CHECK:
  - If enable = 0, go to IDLE.
  - Otherwise, if buf_level ≤ FILL_THRESH, go to CMD; else stay.
- CMD: hold rd_cmd_valid = 1 with rd_cmd_addr = addr until rd_cmd_ready = 1, then go to DATA with beat_cnt = 0.
- DATA: beat_cnt increments on each rd_beat. On the beat where beat_cnt = BURST_LEN−1:
  - If a resync is pending, pulse frame_err and resync (see below).
  - Else if burst_idx = BURSTS_PER_FRAME−1, go to FRAME_END.
  - Else set addr += BURST_LEN×32, burst_idx += 1, and go to CHECK.
- FRAME_END: pulse frame_done for one cycle, then go to WAIT_VS (IDLE if enable = 0).
- Address arithmetic is an accumulator (no multiplier). Addition is modulo 2^32 with no saturation.
- Counters: burst_idx is ⌈log2 BURSTS_PER_FRAME⌉ bits; beat_cnt is ⌈log2 BURST_LEN⌉ bits.
- Vsync edge during CHECK: pulse frame_err, latch the new base, reset addr and burst_idx, stay in CHECK.
- Vsync edge during CMD or DATA: set resync_pend. The command is never withdrawn and the burst runs to its last beat. Then pulse frame_err, latch the new base from frame_sel as sampled at that cycle, and go to CHECK.
- Vsync edge in FRAME_END: treated as a normal frame start; no frame_err.
- enable = 0 during CMD or DATA: finish the handshake and burst, then go to IDLE (pending resync dropped).
- rd_beat outside DATA is ignored.
- Reset at any time: state IDLE, all counters and flags cleared.

## Timing
- Reset values:
  - rd_cmd_valid 0, rd_cmd_addr 0, busy 0, frame_done 0, frame_err 0.
  - vsync_d 0.
  - rd_cmd_len is constant BURST_LEN.
- All outputs are registered.
- Vsync edge at cycle n → CHECK at n+1. With level below threshold → rd_cmd_valid = 1 at n+3.
- Handshake transfers at the edge where valid & ready; rd_cmd_valid = 0 the next cycle.
- rd_cmd_addr is stable while valid is high.
- Last beat at cycle m → CHECK (or FRAME_END) at m+1 → next rd_cmd_valid no earlier than m+3.
- frame_done is high exactly one cycle, at m+2 after the final beat.
- frame_err is high exactly one cycle, the cycle after the resync decision.
- A vsync level held high produces exactly one frame start.

## Test plan
Test parameters: BURST_LEN = 4, BURSTS_PER_FRAME = 3, FRAME_BASE0 = 0x1000, FRAME_BASE1 = 0x8000, FILL_THRESH = 8.
- Nominal frame: enable = 1, frame_sel = 0, buf_level = 0, ready always 1, 4 beats per command, one vsync pulse.
  - Commands at 0x1000, 0x1080, 0x1100.
  - One frame_done; frame_err never asserted.
- Backpressure: hold buf_level = 9 for 20 cycles, and hold ready = 0 for 5 cycles after valid.
  - No command while buf_level > 8.
  - valid and addr stay stable during the stall; exactly one transfer.
- Base select: second frame with frame_sel = 1.
  - Commands at 0x8000, 0x8080, 0x8100; burst_idx restarts.
- Mid-burst vsync: vsync edge after beat 2 of burst 1.
  - Burst completes its 4 beats; one frame_err.
  - Next command at the new base; no frame_done for the aborted frame.
- Disable and reset: enable = 0 during DATA.
  - Burst finishes, busy goes to 0, no further commands.
  - rst_n pulsed low mid-CMD clears rd_cmd_valid asynchronously; all outputs read 0.

Source files
------------

// File: rtl/hdmi_rd_sched.sv
// Frame-read scheduler for the HDMI output path: walks a frame buffer in fixed-length
// DDR read bursts, throttled by the line-buffer fill level and restarted on vsync.
module hdmi_rd_sched #(
  parameter int unsigned BURST_LEN        = 240,
  parameter int unsigned BURSTS_PER_FRAME = 540,
  parameter int unsigned FILL_THRESH      = 1920,
  parameter logic [31:0] FRAME_BASE0      = 32'h0000_0000,
  parameter logic [31:0] FRAME_BASE1      = 32'h0080_0000
) (
  input  logic        hdmi_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        hdmi_vsync,
  input  logic        frame_sel,
  input  logic [15:0] buf_level,
  output logic        rd_cmd_valid,
  input  logic        rd_cmd_ready,
  output logic [31:0] rd_cmd_addr,
  output logic [15:0] rd_cmd_len,
  input  logic        rd_beat,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int unsigned   BW        = $clog2(BURST_LEN);
  localparam int unsigned   IW        = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(BURSTS_PER_FRAME - 1);
  localparam logic [31:0]   ADDR_STEP = 32'(BURST_LEN * 32);
  localparam logic [15:0]   THRESH    = 16'(FILL_THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_CHECK,
    S_CMD,
    S_DATA,
    S_FRAME_END
  } state_t;

  state_t        state_q;
  logic          vsync_q;
  logic [31:0]   addr_q;
  logic [IW-1:0] idx_q;
  logic [BW-1:0] beat_q;
  logic          pend_q;
  logic          pend_sel_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          vs_edge;
  logic          last_beat;
  logic          resync_d;
  logic [31:0]   start_base_d;
  logic [31:0]   resync_base_d;

  assign vs_edge      = hdmi_vsync & ~vsync_q;
  assign last_beat    = rd_beat && (beat_q == BEAT_LAST);
  assign start_base_d = frame_sel ? FRAME_BASE1 : FRAME_BASE0;
  // An edge landing on the final beat itself counts as pending, with frame_sel taken now.
  assign resync_d      = pend_q | vs_edge;
  assign resync_base_d = vs_edge ? start_base_d : (pend_sel_q ? FRAME_BASE1 : FRAME_BASE0);

  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vsync_q    <= 1'b0;
      addr_q     <= '0;
      idx_q      <= '0;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      pend_sel_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vsync_q <= hdmi_vsync;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_WAIT_VS;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT_VS: begin
          if (vs_edge) begin
            addr_q  <= start_base_d;
            idx_q   <= '0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!enable) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (vs_edge) begin
            err_q  <= 1'b1;
            addr_q <= start_base_d;
            idx_q  <= '0;
          end else if (buf_level <= THRESH) begin
            state_q <= S_CMD;
          end
        end
        S_CMD: begin
          if (vs_edge) begin
            pend_q     <= 1'b1;
            pend_sel_q <= frame_sel;
          end
          // valid rises one cycle after entering CMD and is held until accepted
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (rd_cmd_ready) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (last_beat) begin
            pend_q <= 1'b0;
            beat_q <= '0;
            if (!enable) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (resync_d) begin
              err_q   <= 1'b1;
              addr_q  <= resync_base_d;
              idx_q   <= '0;
              state_q <= S_CHECK;
            end else if (idx_q == IDX_LAST) begin
              state_q <= S_FRAME_END;
            end else begin
              addr_q  <= addr_q + ADDR_STEP;
              idx_q   <= idx_q + 1'b1;
              state_q <= S_CHECK;
            end
          end else begin
            if (rd_beat) beat_q <= beat_q + 1'b1;
            if (vs_edge) begin
              pend_q     <= 1'b1;
              pend_sel_q <= frame_sel;
            end
          end
        end
        S_FRAME_END: begin
          done_q <= 1'b1;
          if (!enable) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (vs_edge) begin
            addr_q  <= start_base_d;
            idx_q   <= '0;
            state_q <= S_CHECK;
          end else begin
            state_q <= S_WAIT_VS;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_cmd_valid = valid_q;
  assign rd_cmd_addr  = addr_q;
  assign rd_cmd_len   = 16'(BURST_LEN);
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_hdmi_rd_sched.sv
// Bench for hdmi_rd_sched: directed scenarios plus a randomized run, all checked every
// cycle against a frame-level behavioural model, with literal expectations per scenario.
module tb_hdmi_rd_sched;

  localparam int unsigned BL   = 4;
  localparam int unsigned BPF  = 3;
  localparam int unsigned THR  = 8;
  localparam logic [31:0] B0   = 32'h1000;
  localparam logic [31:0] B1   = 32'h8000;
  localparam logic [31:0] STEP = 32'(BL * 32);

  localparam int P_IDLE = 0, P_WAIT = 1, P_CHECK = 2, P_CMD = 3, P_DATA = 4, P_FEND = 5;

  logic        hdmi_clk = 1'b0;
  logic        rst_n = 1'b0, enable = 1'b0, hdmi_vsync = 1'b0, frame_sel = 1'b0;
  logic        rd_cmd_ready = 1'b0, rd_beat = 1'b0;
  logic [15:0] buf_level = '0;
  logic        rd_cmd_valid, busy, frame_done, frame_err;
  logic [31:0] rd_cmd_addr;
  logic [15:0] rd_cmd_len;

  hdmi_rd_sched #(
    .BURST_LEN(BL),
    .BURSTS_PER_FRAME(BPF),
    .FILL_THRESH(THR),
    .FRAME_BASE0(B0),
    .FRAME_BASE1(B1)
  ) dut (
    .hdmi_clk(hdmi_clk),
    .rst_n(rst_n),
    .enable(enable),
    .hdmi_vsync(hdmi_vsync),
    .frame_sel(frame_sel),
    .buf_level(buf_level),
    .rd_cmd_valid(rd_cmd_valid),
    .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len),
    .rd_beat(rd_beat),
    .busy(busy),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  // stimulus mode
  logic        rst_v = 1'b0, en_v = 1'b0, vs_v = 1'b0, sel_v = 1'b0;
  logic        r_rand = 1'b0, r_val = 1'b1, b_rand = 1'b0, spur = 1'b0;
  logic [15:0] lvl_v = '0;
  int          outst = 0;

  // scoreboard
  int          n_chk = 0, n_pass = 0;
  int          done_cnt = 0, err_cnt = 0, valid_cyc = 0;
  logic [31:0] hs_q[$];

  // behavioural model: frame position as (base, burst number, beats received)
  int          m_ph = P_IDLE, m_k = 0, m_beats = 0;
  logic [31:0] m_base = '0;
  logic        m_vprev = 1'b0, m_pend = 1'b0, m_psel = 1'b0;
  logic        m_valid = 1'b0, m_done = 1'b0, m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] hs_at(input int i);
    return (i < hs_q.size()) ? hs_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic frame_start(input logic s);
    m_base = s ? B1 : B0;
    m_k    = 0;
    m_ph   = P_CHECK;
  endtask

  task automatic burst_end();
    logic p;
    p      = m_pend;
    m_pend = 1'b0;
    if (!enable) m_ph = P_IDLE;
    else if (p) begin
      m_err = 1'b1;
      frame_start(m_psel);
    end else if (m_k == int'(BPF) - 1) m_ph = P_FEND;
    else begin
      m_k++;
      m_ph = P_CHECK;
    end
  endtask

  task automatic model_step();
    logic edge_s;
    if (!rst_n) begin
      m_ph = P_IDLE; m_k = 0; m_beats = 0; m_base = '0;
      m_vprev = 1'b0; m_pend = 1'b0; m_psel = 1'b0;
      m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
      return;
    end
    edge_s  = hdmi_vsync && !m_vprev;
    m_vprev = hdmi_vsync;
    m_done  = 1'b0;
    m_err   = 1'b0;
    case (m_ph)
      P_IDLE:  if (enable) m_ph = P_WAIT;
      P_WAIT:  if (edge_s) frame_start(frame_sel);
      P_CHECK: begin
        if (!enable) m_ph = P_IDLE;
        else if (edge_s) begin
          m_err = 1'b1;
          frame_start(frame_sel);
        end else if (32'(buf_level) <= THR) m_ph = P_CMD;
      end
      P_CMD: begin
        if (edge_s) begin m_pend = 1'b1; m_psel = frame_sel; end
        if (!m_valid) m_valid = 1'b1;
        else if (rd_cmd_ready) begin
          m_valid = 1'b0;
          m_beats = 0;
          m_ph    = P_DATA;
        end
      end
      P_DATA: begin
        if (edge_s) begin m_pend = 1'b1; m_psel = frame_sel; end
        if (rd_beat) begin
          m_beats++;
          if (m_beats == int'(BL)) burst_end();
        end
      end
      P_FEND: begin
        m_done = 1'b1;
        if (!enable) m_ph = P_IDLE;
        else if (edge_s) frame_start(frame_sel);
        else m_ph = P_WAIT;
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  // one clock: drive at negedge, log handshake and step model at posedge, compare after it
  task automatic run1();
    @(negedge hdmi_clk);
    rst_n      = rst_v;
    enable     = en_v;
    hdmi_vsync = vs_v;
    frame_sel  = sel_v;
    buf_level  = lvl_v;
    if (!rst_n) outst = 0;
    if (outst > 0) begin
      rd_beat = b_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rd_beat) outst--;
    end else begin
      rd_beat = spur && ($urandom_range(0, 7) == 0);
    end
    rd_cmd_ready = r_rand ? 1'($urandom_range(0, 1)) : r_val;
    if (rd_cmd_valid && rd_cmd_ready && rst_n) outst += int'(BL);
    @(posedge hdmi_clk);
    if (rd_cmd_valid && rd_cmd_ready && rst_n) hs_q.push_back(rd_cmd_addr);
    model_step();
    #1;
    check("valid", 32'(rd_cmd_valid), 32'(m_valid));
    check("addr",  rd_cmd_addr, m_base + 32'(m_k) * STEP);
    check("busy",  32'(busy), 32'(m_ph != P_IDLE));
    check("done",  32'(frame_done), 32'(m_done));
    check("err",   32'(frame_err), 32'(m_err));
    check("len",   32'(rd_cmd_len), 32'(BL));
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (rd_cmd_valid) valid_cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run1();
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !rd_cmd_valid; i++) run1();
    check("wait_valid", 32'(rd_cmd_valid), 32'd1);
  endtask

  task automatic wait_hs(input int n, input int max);
    for (int i = 0; i < max && hs_q.size() < n; i++) run1();
    check("wait_hs", hs_q.size(), n);
  endtask

  task automatic wait_outst(input int n, input int max);
    for (int i = 0; i < max && outst > n; i++) run1();
    check("wait_beats", outst, n);
  endtask

  initial begin
    // reset
    run_n(3);
    check("rst_valid", 32'(rd_cmd_valid), 32'd0);
    check("rst_addr", rd_cmd_addr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_len", 32'(rd_cmd_len), 32'd4);
    rst_v = 1'b1;
    run_n(2);

    // nominal frame, vsync held high for the whole frame
    en_v = 1'b1; lvl_v = '0; r_val = 1'b1;
    run_n(2);
    check("en_busy", 32'(busy), 32'd1);
    hs_q.delete();
    vs_v = 1'b1;
    run1();
    run1();
    check("vs_valid_n2", 32'(rd_cmd_valid), 32'd0);
    run1();
    check("vs_valid_n3", 32'(rd_cmd_valid), 32'd1);
    check("first_addr", rd_cmd_addr, 32'h1000);
    run_n(40);
    check("nom_cnt", hs_q.size(), 3);
    check("nom_a0", hs_at(0), 32'h1000);
    check("nom_a1", hs_at(1), 32'h1080);
    check("nom_a2", hs_at(2), 32'h1100);
    check("nom_done", done_cnt, 1);
    check("nom_err", err_cnt, 0);

    // backpressure: level above threshold, then a stalled command
    vs_v = 1'b0;
    run1();
    lvl_v = 16'd9; vs_v = 1'b1;
    run1();
    vs_v = 1'b0;
    hs_q.delete(); valid_cyc = 0;
    run_n(20);
    check("bp_no_valid", valid_cyc, 0);
    check("bp_no_cmd", hs_q.size(), 0);
    lvl_v = '0; r_val = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      run1();
      check("stall_valid", 32'(rd_cmd_valid), 32'd1);
      check("stall_addr", rd_cmd_addr, 32'h1000);
    end
    r_val = 1'b1;
    run1();
    check("stall_xfer", hs_q.size(), 1);
    check("stall_drop", 32'(rd_cmd_valid), 32'd0);
    run_n(40);
    check("bp_cnt", hs_q.size(), 3);
    check("bp_a2", hs_at(2), 32'h1100);
    check("bp_done", done_cnt, 2);

    // base select
    hs_q.delete();
    sel_v = 1'b1; vs_v = 1'b1;
    run1();
    vs_v = 1'b0;
    run_n(40);
    check("b1_cnt", hs_q.size(), 3);
    check("b1_a0", hs_at(0), 32'h8000);
    check("b1_a1", hs_at(1), 32'h8080);
    check("b1_a2", hs_at(2), 32'h8100);
    check("b1_done", done_cnt, 3);

    // vsync after beat 2 of burst 1
    hs_q.delete();
    vs_v = 1'b1;
    run1();
    vs_v = 1'b0;
    wait_hs(2, 60);
    wait_outst(2, 20);
    sel_v = 1'b0; vs_v = 1'b1;
    run1();
    vs_v = 1'b0;
    run_n(60);
    check("mid_cnt", hs_q.size(), 5);
    check("mid_a1", hs_at(1), 32'h8080);
    check("mid_a2", hs_at(2), 32'h1000);
    check("mid_a4", hs_at(4), 32'h1100);
    check("mid_err", err_cnt, 1);
    check("mid_done", done_cnt, 4);

    // disable during DATA
    hs_q.delete();
    vs_v = 1'b1;
    run1();
    vs_v = 1'b0;
    wait_hs(1, 20);
    wait_outst(3, 10);
    en_v = 1'b0;
    run_n(20);
    check("dis_cnt", hs_q.size(), 1);
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_valid", 32'(rd_cmd_valid), 32'd0);

    // asynchronous reset while a command is pending
    en_v = 1'b1; r_val = 1'b0;
    run1();
    vs_v = 1'b1;
    run1();
    vs_v = 1'b0;
    wait_valid(10);
    #2;
    rst_n = 1'b0; rst_v = 1'b0; outst = 0;
    #1;
    check("arst_valid", 32'(rd_cmd_valid), 32'd0);
    check("arst_addr", rd_cmd_addr, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(frame_done), 32'd0);
    check("arst_err", 32'(frame_err), 32'd0);
    run_n(2);
    rst_v = 1'b1; r_val = 1'b1;
    run_n(3);

    // randomized traffic
    r_rand = 1'b1; b_rand = 1'b1; spur = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (!rst_v) rst_v = 1'b1;
      else if ($urandom_range(0, 1499) == 0) rst_v = 1'b0;
      if (en_v) en_v = ($urandom_range(0, 199) != 0);
      else en_v = ($urandom_range(0, 9) == 0);
      if (vs_v) vs_v = ($urandom_range(0, 1) == 0);
      else vs_v = ($urandom_range(0, 69) == 0);
      sel_v = 1'($urandom_range(0, 1));
      lvl_v = 16'($urandom_range(0, 12));
      run1();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
